// File: rtl/button_event_pkg.sv
// Shared state encoding and default clock-derived delays for the button
// event chain, so the debouncer and every button_event instance agree.
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Defaults assume a 50 MHz system clock.
  localparam int DEFAULT_LONG_DELAY    = 50_000_000;
  localparam int DEFAULT_REPEAT_PERIOD = 10_000_000;
  localparam int DEFAULT_CNT_W         = 26;

endpackage

// File: rtl/button_event_hold.sv
// Hold timer: free counter with synchronous clear, count enable and a
// terminal compare that flags the cycle in which the count reaches it.
module hold_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] terminal,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = run && (count == terminal);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press, release,
// long-press and auto-repeat pulses plus a registered held level.
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_DELAY    = DEFAULT_LONG_DELAY,
  parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clean,
  input  logic enable,
  output logic press,
  // release and repeat are reserved words, hence the _pulse suffix
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state;
  state_t           next_state;
  logic             prev_clean;
  logic             rise;
  logic             fall;
  logic             press_next;
  logic             release_next;
  logic             long_next;
  logic             repeat_next;
  logic             timer_clear;
  logic             timer_run;
  logic             timer_hit;
  logic [CNT_W-1:0] timer_terminal;

  assign rise           = clean & ~prev_clean;
  assign fall           = ~clean & prev_clean;
  assign timer_terminal = (state == ST_REPEAT) ? REPEAT_TERM : LONG_TERM;

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .run      (timer_run),
    .terminal (timer_terminal),
    .hit      (timer_hit)
  );

  always_comb begin
    next_state   = state;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    timer_clear  = 1'b0;
    timer_run    = 1'b0;
    if (!enable) begin
      next_state  = ST_IDLE;
      timer_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          timer_clear = 1'b1;
          if (rise) begin
            press_next = 1'b1;
            next_state = ST_HELD;
          end
        end
        // A fall always wins over a threshold hit in the same cycle.
        ST_HELD: begin
          timer_run = 1'b1;
          if (fall) begin
            release_next = 1'b1;
            timer_clear  = 1'b1;
            next_state   = ST_IDLE;
          end else if (timer_hit) begin
            long_next   = 1'b1;
            timer_clear = 1'b1;
            next_state  = ST_REPEAT;
          end
        end
        ST_REPEAT: begin
          timer_run = 1'b1;
          if (fall) begin
            release_next = 1'b1;
            timer_clear  = 1'b1;
            next_state   = ST_IDLE;
          end else if (timer_hit) begin
            repeat_next = 1'b1;
            timer_clear = 1'b1;
          end
        end
        default: begin
          timer_clear = 1'b1;
          next_state  = ST_IDLE;
        end
      endcase
    end
  end

  // prev_clean resets high so a button held through reset is not a press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      prev_clean    <= 1'b1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= next_state;
      prev_clean    <= clean;
      press         <= press_next;
      release_pulse <= release_next;
      long_press    <= long_next;
      repeat_pulse  <= repeat_next;
      held          <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: directed scenarios plus randomized
// button activity, checked against a press-age reference model.
module tb_button_event;

  localparam int LONG  = 8;
  localparam int REP   = 4;
  localparam int CNT_W = 4;

  logic clock;
  logic reset_n;
  logic clean;
  logic enable;
  logic press;
  logic release_pulse;
  logic long_press;
  logic repeat_pulse;
  logic held;
  logic [4:0] obs;

  int tests_run;
  int tests_failed;

  // Reference model: tracks whether a press is active and its age in cycles.
  logic       m_prev;
  logic       m_active;
  int         m_age;
  logic [4:0] exp_out;

  button_event #(
    .LONG_DELAY    (LONG),
    .REPEAT_PERIOD (REP),
    .CNT_W         (CNT_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clean         (clean),
    .enable        (enable),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  assign obs = {press, release_pulse, long_press, repeat_pulse, held};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_edge(input logic c, input logic en);
    logic r;
    logic f;
    r = c & ~m_prev;
    f = ~c & m_prev;
    m_prev = c;
    exp_out = '0;
    if (!en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (r) begin
        m_active = 1'b1;
        m_age = 0;
        exp_out[4] = 1'b1;
      end
    end else begin
      m_age = m_age + 1;
      if (f) begin
        exp_out[3] = 1'b1;
        m_active = 1'b0;
      end else if (m_age == LONG) begin
        exp_out[2] = 1'b1;
      end else if (m_age > LONG && ((m_age - LONG) % REP) == 0) begin
        exp_out[1] = 1'b1;
      end
    end
    exp_out[0] = m_active;
  endfunction

  task automatic step(input logic c, input logic en);
    clean  = c;
    enable = en;
    @(posedge clock);
    model_edge(c, en);
    #1;
  endtask

  task automatic do_reset(input logic c);
    clean    = c;
    enable   = 1'b1;
    reset_n  = 1'b0;
    m_prev   = 1'b1;
    m_active = 1'b0;
    m_age    = 0;
    exp_out  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    tests_run++;
    if (obs !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got %b want %b", obs, 5'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("[TB] FAIL reset_idle cyc %0d got %b want %b", i, obs, exp_out);
      end
    end
  endtask

  task automatic test_short_press;
    logic [3:0] pattern [6];
    pattern = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(pattern[i][0], 1'b1);
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("[TB] FAIL short_press cyc %0d got %b want %b", i, obs, exp_out);
      end
    end
  endtask

  task automatic test_long_hold;
    int pulses;
    for (int k = 0; k < 24; k++) begin
      step(k < 20 ? 1'b1 : 1'b0, 1'b1);
      pulses = int'(press) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse);
      tests_run++;
      if (obs !== exp_out || pulses > 1) begin
        tests_failed++;
        $display("[TB] FAIL long_hold cyc %0d got %b want %b", k, obs, exp_out);
      end
    end
  endtask

  task automatic test_fall_at_threshold;
    step(1'b1, 1'b1);
    for (int k = 1; k < LONG; k++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    tests_run++;
    if (release_pulse !== 1'b1 || long_press !== 1'b0 || held !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fall_at_threshold got rel=%b long=%b held=%b want rel=1 long=0 held=0",
               release_pulse, long_press, held);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1);
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("[TB] FAIL fall_at_threshold_after cyc %0d got %b want %b", k, obs, exp_out);
      end
    end
  endtask

  task automatic test_held_through_reset;
    int presses;
    presses = 0;
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      step(k == 5 ? 1'b0 : 1'b1, 1'b1);
      presses += int'(press);
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("[TB] FAIL held_through_reset cyc %0d got %b want %b", k, obs, exp_out);
      end
    end
    tests_run++;
    if (presses != 1) begin
      tests_failed++;
      $display("[TB] FAIL held_through_reset_presses got %0d want 1", presses);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
  endtask

  task automatic test_enable_drop;
    int events;
    events = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, (k >= 4 && k < 7) ? 1'b0 : 1'b1);
      if (k >= 4) events += int'(press) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse);
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("[TB] FAIL enable_drop cyc %0d got %b want %b", k, obs, exp_out);
      end
    end
    tests_run++;
    if (events != 0 || held !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL enable_drop_quiet got events=%0d held=%b want events=0 held=0", events, held);
    end
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    tests_run++;
    if (press !== 1'b1 || obs !== exp_out) begin
      tests_failed++;
      $display("[TB] FAIL enable_repress got %b want %b", obs, exp_out);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
  endtask

  task automatic test_reset_in_repeat;
    int events;
    events = 0;
    for (int k = 0; k < LONG + 2; k++) step(1'b1, 1'b1);
    tests_run++;
    if (held !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_repeat_pre got held=%b want 1", held);
    end
    #2;
    reset_n  = 1'b0;
    m_prev   = 1'b1;
    m_active = 1'b0;
    exp_out  = '0;
    #1;
    tests_run++;
    if (obs !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_repeat_async got %b want %b", obs, 5'b0);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1);
      events += int'(press) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse);
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("[TB] FAIL reset_in_repeat_after cyc %0d got %b want %b", k, obs, exp_out);
      end
    end
    tests_run++;
    if (events != 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_repeat_events got %0d want 0", events);
    end
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic lvl;
    logic en;
    int   len;
    int   pulses;
    for (int n = 0; n < 40; n++) begin
      lvl = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        step(lvl, en);
        pulses = int'(press) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse);
        tests_run++;
        if (obs !== exp_out || pulses > 1) begin
          tests_failed++;
          $display("[TB] FAIL random run %0d cyc %0d got %b want %b", n, i, obs, exp_out);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    clean        = 1'b0;
    enable       = 1'b1;
    test_reset();
    test_short_press();
    test_long_hold();
    test_fall_at_threshold();
    test_held_through_reset();
    test_enable_drop();
    test_reset_in_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
